// File: rtl/snddma_seq.sv
// snddma_seq: multi-channel sound DMA word-address sequencer.
// Each channel plays a frame [lbase, lend) with double-buffered base/end
// registers, optional repeat, and a maskable frame interrupt. One grant per
// clk is issued round-robin among running channels that request data.
module snddma_seq #(
  parameter int NCH = 2,
  parameter int AW  = 21,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            resb,
  input  logic            wr,
  input  logic [CW-1:0]   wch,
  input  logic [1:0]      wsel,
  input  logic [AW-1:0]   wdata,
  input  logic [NCH-1:0]  sreq,
  input  logic            slot,
  output logic [AW-1:0]   addr,
  output logic [CW-1:0]   ach,
  output logic            aval,
  output logic [NCH-1:0]  run,
  output logic [NCH-1:0]  sframe,
  output logic [NCH-1:0]  stoff,
  output logic            sint
);

  logic [NCH-1:0][AW-1:0] pbase, pend, lbase, lend, cnt, nxt;
  logic [NCH-1:0]         rpt, ien, irq;
  logic [NCH-1:0]         elig, hit, wctl, wbase, wend, fend, start, rej, iset;
  logic [CW-1:0]          ptr, gch;
  logic                   gnt;

  assign elig = run & sreq;
  assign sint = |(irq & ien);

  // Round-robin pick: scan from farthest to nearest after ptr so the
  // nearest eligible channel is the one left in gch.
  always_comb begin
    logic [CW-1:0] idx;
    idx = '0;
    gnt = 1'b0;
    gch = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = CW'((int'(ptr) + k) % NCH);
      if (elig[idx]) begin
        gnt = slot;
        gch = idx;
      end
    end
  end

  // Per-channel decode of this clk's write and grant events.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wctl[c]  = wr && (wsel == 2'd0) && (wch == CW'(c));
      wbase[c] = wr && (wsel == 2'd1) && (wch == CW'(c));
      wend[c]  = wr && (wsel == 2'd2) && (wch == CW'(c));
      hit[c]   = gnt && (gch == CW'(c));
      nxt[c]   = cnt[c] + AW'(1);
      fend[c]  = hit[c] && (nxt[c] == lend[c]);
      // start decision uses pre-clk run, so a same-clk frame end does not restart
      start[c] = wctl[c] && wdata[0] && !run[c];
      rej[c]   = start[c] && (pbase[c] == pend[c]);
      iset[c]  = fend[c] || rej[c];
    end
  end

  // Grant output register and round-robin pointer.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      aval <= 1'b0;
      addr <= '0;
      ach  <= '0;
      ptr  <= CW'(NCH - 1);
    end else begin
      aval <= gnt;
      if (gnt) begin
        addr <= cnt[gch];
        ach  <= gch;
        ptr  <= gch;
      end
    end
  end

  // Channel state: grant effects first, CPU write effects last so a
  // disable in the same clk as a grant still ends with run=0.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      pbase  <= '0;
      pend   <= '0;
      lbase  <= '0;
      lend   <= '0;
      cnt    <= '0;
      rpt    <= '0;
      ien    <= '0;
      irq    <= '0;
      run    <= '0;
      sframe <= '0;
      stoff  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        sframe[c] <= 1'b0;
        stoff[c]  <= 1'b0;
        if (wbase[c]) pbase[c] <= wdata;
        if (wend[c])  pend[c]  <= wdata;
        if (hit[c]) begin
          if (fend[c]) begin
            if (rpt[c]) begin
              // reload sees pending values from before this clk's write
              lbase[c]  <= pbase[c];
              lend[c]   <= pend[c];
              cnt[c]    <= pbase[c];
              sframe[c] <= 1'b1;
            end else begin
              run[c]   <= 1'b0;
              stoff[c] <= 1'b1;
            end
          end else begin
            cnt[c] <= nxt[c];
          end
        end
        if (wctl[c]) begin
          rpt[c] <= wdata[1];
          ien[c] <= wdata[3];
          if (!wdata[0]) begin
            run[c] <= 1'b0;
          end else if (start[c]) begin
            if (rej[c]) begin
              stoff[c] <= 1'b1;
            end else begin
              lbase[c]  <= pbase[c];
              lend[c]   <= pend[c];
              cnt[c]    <= pbase[c];
              run[c]    <= 1'b1;
              sframe[c] <= 1'b1;
            end
          end
        end
        // a frame-end set beats a same-clk write-1 clear
        irq[c] <= iset[c] | (irq[c] & ~(wctl[c] & wdata[2]));
      end
    end
  end

endmodule

// File: tb/tb_snddma_seq.sv
// Testbench for snddma_seq: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_snddma_seq;
  localparam int NCH = 2;
  localparam int AW  = 21;
  localparam int CW  = 1;

  logic            clk = 1'b0;
  logic            resb = 1'b0;
  logic            wr = 1'b0;
  logic [CW-1:0]   wch = '0;
  logic [1:0]      wsel = '0;
  logic [AW-1:0]   wdata = '0;
  logic [NCH-1:0]  sreq = '0;
  logic            slot = 1'b0;
  logic [AW-1:0]   addr;
  logic [CW-1:0]   ach;
  logic            aval;
  logic [NCH-1:0]  run, sframe, stoff;
  logic            sint;

  int n_chk = 0;
  int n_fail = 0;

  snddma_seq #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .resb(resb), .wr(wr), .wch(wch), .wsel(wsel), .wdata(wdata),
    .sreq(sreq), .slot(slot), .addr(addr), .ach(ach), .aval(aval),
    .run(run), .sframe(sframe), .stoff(stoff), .sint(sint)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [AW-1:0]  m_pb[NCH], m_pe[NCH], m_lb[NCH], m_le[NCH], m_cnt[NCH];
  bit [NCH-1:0] m_run = '0, m_rpt = '0, m_ien = '0, m_irq = '0;
  int           m_last = NCH - 1;
  bit           e_aval = 1'b0;
  bit [AW-1:0]  e_addr = '0;
  bit [CW-1:0]  e_ach = '0;
  bit [NCH-1:0] e_sframe = '0, e_stoff = '0;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pb[c] = '0; m_pe[c] = '0; m_lb[c] = '0; m_le[c] = '0; m_cnt[c] = '0;
    end
    m_run = '0; m_rpt = '0; m_ien = '0; m_irq = '0;
    m_last = NCH - 1;
    e_aval = 1'b0; e_addr = '0; e_ach = '0; e_sframe = '0; e_stoff = '0;
  endtask

  // One clk of the playback rules: serve a grant, then apply the CPU write.
  always @(posedge clk or negedge resb) begin
    int g;
    int wc;
    bit [NCH-1:0] setnow, run0;
    bit [AW-1:0] nx;
    if (!resb) begin
      m_reset();
    end else begin
      g = -1; setnow = '0; run0 = m_run;
      e_aval = 1'b0; e_sframe = '0; e_stoff = '0;
      if (slot) begin
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (m_run[c] && sreq[c]) begin g = c; break; end
        end
      end
      if (g >= 0) begin
        e_aval = 1'b1; e_addr = m_cnt[g]; e_ach = g[CW-1:0]; m_last = g;
        nx = m_cnt[g] + 1'b1;
        if (nx == m_le[g]) begin
          setnow[g] = 1'b1;
          if (m_rpt[g]) begin
            m_lb[g] = m_pb[g]; m_le[g] = m_pe[g]; m_cnt[g] = m_pb[g]; e_sframe[g] = 1'b1;
          end else begin
            m_run[g] = 1'b0; e_stoff[g] = 1'b1;
          end
        end else begin
          m_cnt[g] = nx;
        end
      end
      if (wr) begin
        wc = int'(wch);
        if (wsel == 2'd1) m_pb[wc] = wdata;
        else if (wsel == 2'd2) m_pe[wc] = wdata;
        else if (wsel == 2'd0) begin
          if (!wdata[0]) m_run[wc] = 1'b0;
          else if (!run0[wc]) begin
            if (m_pb[wc] == m_pe[wc]) begin
              e_stoff[wc] = 1'b1; setnow[wc] = 1'b1;
            end else begin
              m_lb[wc] = m_pb[wc]; m_le[wc] = m_pe[wc]; m_cnt[wc] = m_pb[wc];
              m_run[wc] = 1'b1; e_sframe[wc] = 1'b1;
            end
          end
          m_rpt[wc] = wdata[1];
          m_ien[wc] = wdata[3];
          if (wdata[2]) m_irq[wc] = 1'b0;
        end
      end
      m_irq = m_irq | setnow;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wreg(input int ch, input int sel, input int d);
    wr = 1'b1; wch = ch[CW-1:0]; wsel = sel[1:0]; wdata = d[AW-1:0];
    @(negedge clk);
    wr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resb = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({addr, ach, aval, run, sframe, stoff, sint} !== '0) begin
      n_fail++;
      $display("FAIL reset: addr=%h ach=%0d aval=%b run=%b sframe=%b stoff=%b sint=%b, want all 0",
               addr, ach, aval, run, sframe, stoff, sint);
    end
    resb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    logic [AW-1:0] got[$];
    int so_at, so_n;
    so_at = -1; so_n = 0;
    wreg(0, 1, 'h100); wreg(0, 2, 'h103);
    sreq = 2'b01; slot = 1'b1;
    wreg(0, 0, 'h1);
    n_chk++;
    if (run[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_run: run0=%b want 1", run[0]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (aval) got.push_back(addr);
      if (stoff[0]) begin so_n++; so_at = got.size(); end
    end
    n_chk++;
    if (got.size() != 3 || got[0] !== 21'h100 || got[1] !== 21'h101 || got[2] !== 21'h102) begin
      n_fail++;
      $display("FAIL oneshot_addrs: got %0d grants first=%h, want 100 101 102",
               got.size(), (got.size() > 0) ? got[0] : 21'h0);
    end
    n_chk++;
    if (so_n != 1 || so_at != 3) begin
      n_fail++; $display("FAIL oneshot_stoff: pulses=%0d at grant %0d, want 1 at 3", so_n, so_at);
    end
    n_chk++;
    if (run[0] !== 1'b0 || sint !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_end: run0=%b sint=%b want 0 0", run[0], sint);
    end
    sreq = '0;
    wreg(0, 0, 'h8);
    n_chk++;
    if (sint !== 1'b1) begin n_fail++; $display("FAIL oneshot_sint_en: sint=%b want 1", sint); end
    wreg(0, 0, 'hC);
    n_chk++;
    if (sint !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clr: sint=%b want 0", sint); end
    wreg(0, 0, 'h0);
  endtask

  task automatic test_repeat();
    bit seen;
    logic [AW-1:0] want[6];
    want = '{21'h11, 21'h40, 21'h40, 21'h40, 21'h40, 21'h40};
    seen = 1'b0;
    wreg(0, 1, 'h10); wreg(0, 2, 'h12);
    wreg(0, 0, 'h3);
    sreq = 2'b01;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (aval) begin
        seen = 1'b1;
        sreq = '0;
        n_chk++;
        if (addr !== 21'h10) begin n_fail++; $display("FAIL repeat_first: addr=%h want 10", addr); end
      end
    end
    if (!seen) begin n_chk++; n_fail++; $display("FAIL repeat_first: no grant within 5 clks"); end
    wreg(0, 1, 'h40); wreg(0, 2, 'h41);
    sreq = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (aval !== 1'b1 || addr !== want[i] || sframe[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL repeat_seq[%0d]: aval=%b addr=%h sframe0=%b want 1 %h 1",
                 i, aval, addr, sframe[0], want[i]);
      end
    end
    sreq = '0;
    wreg(0, 0, 'h0);
    n_chk++;
    if (run[0] !== 1'b0) begin n_fail++; $display("FAIL repeat_stop: run0=%b want 0", run[0]); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] wa[4];
    logic [CW-1:0] wc[4];
    wa = '{21'h200, 21'h300, 21'h201, 21'h301};
    wc = '{1'b0, 1'b1, 1'b0, 1'b1};
    resb = 1'b0; @(negedge clk); resb = 1'b1;
    wreg(0, 1, 'h200); wreg(0, 2, 'h280);
    wreg(1, 1, 'h300); wreg(1, 2, 'h380);
    wreg(0, 0, 'h1); wreg(1, 0, 'h1);
    sreq = 2'b11; slot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (aval !== 1'b1 || ach !== wc[i] || addr !== wa[i]) begin
        n_fail++;
        $display("FAIL rr[%0d]: aval=%b ach=%0d addr=%h want 1 %0d %h", i, aval, ach, addr, wc[i], wa[i]);
      end
    end
    sreq = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (aval !== 1'b1 || ach !== 1'b0 || addr !== 21'(32'h202 + i)) begin
        n_fail++;
        $display("FAIL rr_ch0only[%0d]: aval=%b ach=%0d addr=%h want 1 0 %h", i, aval, ach, addr, 32'h202 + i);
      end
    end
    sreq = '0;
    wreg(0, 0, 'h0); wreg(1, 0, 'h0);
  endtask

  task automatic test_boundary();
    logic [AW-1:0] got[$];
    int so_n;
    so_n = 0;
    wreg(1, 1, 'h50); wreg(1, 2, 'h50);
    wreg(1, 0, 'h1);
    n_chk++;
    if (run[1] !== 1'b0 || stoff[1] !== 1'b1 || sframe[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_start: run1=%b stoff1=%b sframe1=%b want 0 1 0", run[1], stoff[1], sframe[1]);
    end
    wreg(1, 0, 'h8);
    n_chk++;
    if (sint !== 1'b1) begin n_fail++; $display("FAIL empty_irq: sint=%b want 1", sint); end
    wreg(1, 0, 'h4);
    wreg(0, 1, 'h1FFFFF); wreg(0, 2, 'h1);
    wreg(0, 0, 'h1);
    sreq = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (aval) got.push_back(addr);
      if (stoff[0]) so_n++;
    end
    n_chk++;
    if (got.size() != 2 || got[0] !== 21'h1FFFFF || got[1] !== 21'h0 || so_n != 1 || run[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: grants=%0d first=%h stoff=%0d run0=%b want 2 1fffff 1 0",
               got.size(), (got.size() > 0) ? got[0] : 21'h0, so_n, run[0]);
    end
    sreq = '0;
    wreg(0, 0, 'h4);
  endtask

  task automatic test_simultaneous();
    wreg(0, 1, 'h500); wreg(0, 2, 'h510);
    wreg(0, 0, 'h1);
    sreq = 2'b01;
    @(negedge clk);
    wr = 1'b1; wch = '0; wsel = 2'd0; wdata = '0;
    @(negedge clk);
    wr = 1'b0;
    n_chk++;
    if (aval !== 1'b1 || addr !== 21'h501 || run[0] !== 1'b0 || stoff[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_grant: aval=%b addr=%h run0=%b stoff0=%b want 1 501 0 0", aval, addr, run[0], stoff[0]);
    end
    @(negedge clk);
    n_chk++;
    if (aval !== 1'b0) begin n_fail++; $display("FAIL disable_after: aval=%b want 0", aval); end
    sreq = '0;
    wreg(0, 1, 'h600); wreg(0, 2, 'h602);
    wreg(0, 0, 'h9);
    sreq = 2'b01;
    @(negedge clk);
    wr = 1'b1; wch = '0; wsel = 2'd0; wdata = 21'hD;
    @(negedge clk);
    wr = 1'b0;
    n_chk++;
    if (aval !== 1'b1 || addr !== 21'h601 || stoff[0] !== 1'b1 || sint !== 1'b1 || run[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_set_wins: aval=%b addr=%h stoff0=%b sint=%b run0=%b want 1 601 1 1 0",
               aval, addr, stoff[0], sint, run[0]);
    end
    sreq = '0;
    wreg(0, 0, 'h4);
  endtask

  task automatic test_reset_mid();
    wreg(0, 1, 'h700); wreg(0, 2, 'h7FF);
    wreg(1, 1, 'h800); wreg(1, 2, 'h8FF);
    wreg(0, 0, 'h9); wreg(1, 0, 'h1);
    sreq = 2'b11;
    repeat (3) @(negedge clk);
    #2 resb = 1'b0;
    #1;
    n_chk++;
    if ({addr, ach, aval, run, sframe, stoff, sint} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: addr=%h ach=%0d aval=%b run=%b sframe=%b stoff=%b sint=%b, want all 0",
               addr, ach, aval, run, sframe, stoff, sint);
    end
    sreq = '0;
    @(negedge clk);
    resb = 1'b1;
    wreg(1, 1, 'h800); wreg(1, 2, 'h8FF); wreg(1, 0, 'h1);
    wreg(0, 1, 'h700); wreg(0, 2, 'h7FF); wreg(0, 0, 'h1);
    sreq = 2'b11;
    @(negedge clk);
    n_chk++;
    if (aval !== 1'b1 || ach !== 1'b0 || addr !== 21'h700) begin
      n_fail++;
      $display("FAIL reset_first_grant: aval=%b ach=%0d addr=%h want 1 0 700", aval, ach, addr);
    end
    sreq = '0;
    wreg(0, 0, 'h0); wreg(1, 0, 'h0);
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      ea = e_addr;
      n_chk++;
      if (aval !== e_aval || addr !== ea || ach !== e_ach || run !== m_run ||
          sframe !== e_sframe || stoff !== e_stoff || sint !== |(m_irq & m_ien)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got aval=%b addr=%h ach=%0d run=%b sf=%b so=%b sint=%b; want %b %h %0d %b %b %b %b",
                 i, aval, addr, ach, run, sframe, stoff, sint,
                 e_aval, ea, e_ach, m_run, e_sframe, e_stoff, |(m_irq & m_ien));
      end
      wr   = ($urandom_range(0, 2) == 0);
      wch  = CW'($urandom_range(0, NCH - 1));
      wsel = 2'($urandom_range(0, 3));
      if (wsel == 2'd0) wdata = AW'({$urandom_range(0, 7), ($urandom_range(0, 3) != 0)});
      else              wdata = AW'($urandom_range(0, 7)) - AW'(2);
      sreq = NCH'($urandom);
      slot = ($urandom_range(0, 3) != 0);
    end
    wr = 1'b0; sreq = '0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_repeat();
    test_round_robin();
    test_boundary();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snddma_seq.md
# snddma_seq

Parametrised multi-channel sound DMA address sequencer. It replaces the single fixed sound frame counter with NCH independent channels. Each channel has double-buffered frame base/end registers, one-shot or repeat playback, frame-start and stop strobes, and a maskable frame interrupt. It sits between the CPU register decode and the address bus mux. On each sound bus slot it supplies one word address, chosen round-robin among the channels requesting data.

## Interface
Parameters:
- NCH, 2: number of channels, 1..8.
- AW, 21: word-address width, matching ADDR[21:1].
- CW, derived: max(1, clog2(NCH)). Width of a channel index.

Ports:
- clk  in  1  system clock.
- resb  in  1  asynchronous, active-low reset.
- wr  in  1  register write strobe, one clk wide.
- wch  in  CW  channel selected for the write.
- wsel  in  2  register select: 0 = ctrl, 1 = base, 2 = end, 3 = ignored.
- wdata  in  AW  write data. Ctrl uses only bits [3:0].
- sreq  in  NCH  per-channel word request from the sample FIFO, level.
- slot  in  1  a sound DMA bus slot is available this clk.
- addr  out  AW  granted word address.
- ach  out  CW  granted channel.
- aval  out  1  addr and ach are valid, one clk per grant.
- run  out  NCH  channel is playing.
- sframe  out  NCH  one-clk pulse when a frame (re)starts.
- stoff  out  NCH  one-clk pulse when a channel stops itself.
- sint  out  1  OR over channels of (irq flag AND irq enable).

## Operation
- Per-channel registers:
  - pbase and pend: pending values, written by the CPU.
  - lbase and lend: live values.
  - cnt: AW-bit counter.
  - Flags: rpt, ien, irq, run.
- Ctrl write fields:
  - wdata[0] = enable.
  - wdata[1] = repeat, stored in rpt.
  - wdata[2] = write-1 clears irq.
  - wdata[3] = irq enable, stored in ien.
- Base and end writes update only pbase/pend. They never disturb a playing frame.
- Start: ctrl write with enable=1 while run=0.
  - If pbase == pend: the start is rejected. run stays 0, stoff pulses, irq is set.
  - Otherwise: lbase←pbase, lend←pend, cnt←pbase, run←1, sframe pulses.
- Enable=1 written while already running: only rpt, ien and the irq clear take effect.
- Stop by CPU: ctrl write with enable=0 clears run. No stoff pulse, no irq.
- Arbitration:
  - A channel is eligible when run & sreq.
  - When slot=1 and at least one channel is eligible, the eligible channel nearest after the last-granted channel wins (round-robin).
  - Grant: addr←cnt, ach←channel, aval←1 on the next clk, and cnt←cnt+1.
- Frame end: the granted cnt+1 equals lend (lend is exclusive).
  - rpt=1: lbase←pbase, lend←pend, cnt←pbase, sframe pulses, irq←1.
  - rpt=0: run←0, stoff pulses, irq←1.
- Wrap-around: cnt increments modulo 2^AW. base > end is legal and plays through address 0.
- Simultaneous events:
  - A grant uses the state from before the write. A ctrl disable and a grant on the same channel in the same clk both take effect: the address is issued, then run=0.
  - When irq is set by a frame end and cleared by a write in the same clk, set wins.
  - A write to pbase or pend in the same clk as a repeat reload is not seen by that reload. It applies at the next reload.
- slot=1 with no eligible channel: no grant and no pointer change.

## Timing
- Reset (resb=0), asynchronous:
  - All registers and outputs go to 0: addr=0, ach=0, aval=0, run=0, sframe=0, stoff=0, sint=0.
  - The round-robin pointer goes to NCH-1, so channel 0 wins first.
- Grant latency: aval/addr/ach are registered and valid exactly 1 clk after the slot=1 cycle. There is at most one grant per clk.
- sframe and stoff are registered, asserted 1 clk after the causing write or grant.
- run updates 1 clk after the causing write or grant.
- sint is combinational from the irq and ien registers. It rises 1 clk after the frame end and falls 1 clk after the clearing write.
- No back-pressure: a grant with aval=1 is always consumed.

## Test plan
- Single channel, one-shot:
  - Stimulus: NCH=2; ch0 base=0x100, end=0x103, ctrl=0x1; sreq[0]=1, slot every clk.
  - Expected: aval with addr 0x100, 0x101, 0x102 on consecutive clks. stoff[0] pulses 1 clk after the last grant, then run[0]=0.
  - Expected: irq set; sint=0 because ien=0, then sint=1 after writing ctrl=0x8.
- Repeat with double buffering:
  - Stimulus: ch0 base=0x10, end=0x12, ctrl=0x3. After the first grant, write base=0x40, end=0x41.
  - Expected sequence: 0x10, 0x11, sframe, then 0x40, 0x40, ... with sframe on every reload.
- Round-robin:
  - Stimulus: ch0 cnt at 0x200, ch1 cnt at 0x300, both requesting, slot every clk.
  - Expected: ach toggles 0,1,0,1 and addr goes 0x200, 0x300, 0x201, 0x301.
  - Expected: dropping sreq[1] gives only ch0 grants.
- Boundary cases:
  - Start with base=end=0x50: run stays 0, stoff pulses, irq=1.
  - base=0x1FFFFF, end=0x000001: addresses 0x1FFFFF then 0x000000, then stop.
- Simultaneous and reset:
  - Disable ch0 in the same clk as its grant: the address is still issued, run[0]=0 after, no stoff.
  - Frame-end irq set together with a clear write: irq ends up 1.
  - resb low mid-frame: all outputs 0 immediately; after release, ch0 wins the first grant.
